// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 serial slave and any master driver:
// command field codes, command bit positions and the frame state encoding.
package tm1638_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_DATA = 2'b01;
  localparam logic [1:0] FIELD_DISP = 2'b10;
  localparam logic [1:0] FIELD_ADDR = 2'b11;

  localparam int BIT_READ    = 1;
  localparam int BIT_FIXED   = 2;
  localparam int BIT_DISP_ON = 3;

  function automatic logic [1:0] cmd_field(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchronizer for one serial input plus rise/fall detection on
// the synchronized level. Everything presets to 1 so an idle-high line shows no edge.
module tm1638_sync_edge #(
  parameter int C_SYNC = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [C_SYNC-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[C_SYNC-2:0], i_d};
      r_prev <= r_sync[C_SYNC-1];
    end
  end

  assign o_q    = r_sync[C_SYNC-1];
  assign o_rise = r_sync[C_SYNC-1] & ~r_prev;
  assign o_fall = ~r_sync[C_SYNC-1] & r_prev;

endmodule

// File: rtl/tm1638_slave.sv
// TM1638-style serial slave: decodes command/address/data frames from an
// external master into a 16x8 display RAM and shifts a 32-bit key image back out.
module tm1638_slave
  import tm1638_pkg::*;
#(
  parameter int C_SYNC = 2
) (
  input  logic        CK_i,
  input  logic        ARST_i,
  input  logic        STB_i,
  input  logic        SCLK_i,
  input  logic        DIO_i,
  output logic        DIO_o,
  output logic        DIO_OE_o,
  input  logic [31:0] KEYS_i,
  input  logic [3:0]  RAM_RADR_i,
  output logic [7:0]  RAM_RDAT_o,
  output logic        DISP_ON_o,
  output logic [2:0]  BRIGHT_o,
  output logic        FRAME_ERR_o,
  output state_t      DBG_STATE_o
);

  logic w_stb, w_stb_rise, w_stb_fall;
  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_dio, w_dio_rise, w_dio_fall;
  logic w_unused;

  tm1638_sync_edge #(.C_SYNC(C_SYNC)) u_sync_stb (
    .i_clk(CK_i), .i_rst(ARST_i), .i_d(STB_i),
    .o_q(w_stb), .o_rise(w_stb_rise), .o_fall(w_stb_fall));
  tm1638_sync_edge #(.C_SYNC(C_SYNC)) u_sync_sclk (
    .i_clk(CK_i), .i_rst(ARST_i), .i_d(SCLK_i),
    .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  tm1638_sync_edge #(.C_SYNC(C_SYNC)) u_sync_dio (
    .i_clk(CK_i), .i_rst(ARST_i), .i_d(DIO_i),
    .o_q(w_dio), .o_rise(w_dio_rise), .o_fall(w_dio_fall));

  assign w_unused = ^{w_sclk, w_dio_rise, w_dio_fall};

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [3:0]  r_addr;
  logic        r_fixed;
  logic        r_disp_on;
  logic [2:0]  r_bright;
  logic [31:0] r_keys;
  logic [4:0]  r_rbit;
  logic        r_rd_armed;
  logic        r_dio, r_oe, r_frame_err;
  logic [7:0]  r_ram [16];

  logic       w_in_shift, w_sclk_ok, w_shift_en, w_byte_done;
  logic [7:0] w_byte;

  // A strobe edge in the same cycle as a clock edge swallows the clock edge.
  assign w_in_shift  = (r_state == ST_CMD) || (r_state == ST_WDATA);
  assign w_sclk_ok   = ~w_stb & ~w_stb_fall;
  assign w_shift_en  = w_sclk_ok & w_in_shift & w_sclk_rise;
  assign w_byte_done = w_shift_en & (r_cnt == 3'd7);
  assign w_byte      = {w_dio, r_shift[7:1]};

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stb_fall) begin
      w_state_nxt = ST_CMD;
    end else if (w_stb) begin
      w_state_nxt = ST_IDLE;
    end else if (w_byte_done && r_state == ST_CMD) begin
      case (cmd_field(w_byte))
        FIELD_DATA: w_state_nxt = w_byte[BIT_READ] ? ST_RDATA : ST_WDATA;
        FIELD_ADDR: w_state_nxt = ST_WDATA;
        default:    w_state_nxt = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_fixed     <= 1'b0;
      r_disp_on   <= 1'b0;
      r_bright    <= '0;
      r_keys      <= '0;
      r_rbit      <= '0;
      r_rd_armed  <= 1'b0;
      r_dio       <= 1'b0;
      r_oe        <= 1'b0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < 16; i++) r_ram[i] <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_stb_fall) begin
        r_cnt <= '0;
        r_oe  <= 1'b0;
      end else if (w_stb) begin
        r_cnt       <= '0;
        r_oe        <= 1'b0;
        r_frame_err <= w_stb_rise & w_in_shift & (r_cnt != 3'd0);
      end else begin
        if (w_shift_en) begin
          r_shift <= w_byte;
          r_cnt   <= r_cnt + 3'd1;
        end
        if (w_byte_done && r_state == ST_CMD) begin
          case (cmd_field(w_byte))
            FIELD_DATA: begin
              r_fixed <= w_byte[BIT_FIXED];
              if (w_byte[BIT_READ]) begin
                r_keys     <= KEYS_i;
                r_oe       <= 1'b1;
                r_dio      <= KEYS_i[0];
                r_rbit     <= 5'd1;
                r_rd_armed <= 1'b0;
              end
            end
            FIELD_ADDR: r_addr <= w_byte[3:0];
            FIELD_DISP: begin
              r_disp_on <= w_byte[BIT_DISP_ON];
              r_bright  <= w_byte[2:0];
            end
            default: ;
          endcase
        end
        if (w_byte_done && r_state == ST_WDATA) begin
          r_ram[r_addr] <= w_byte;
          if (!r_fixed) r_addr <= r_addr + 4'd1;
        end
        // The falling edge right after the read command is not preceded by a
        // rising edge in RDATA, so bit 0 stays put until the master samples it.
        if (r_state == ST_RDATA) begin
          if (w_sclk_rise) begin
            r_rd_armed <= 1'b1;
          end else if (w_sclk_fall && r_rd_armed) begin
            r_dio      <= r_keys[r_rbit];
            r_rbit     <= r_rbit + 5'd1;
            r_rd_armed <= 1'b0;
          end
        end
      end
    end
  end

  assign DIO_o       = r_dio;
  assign DIO_OE_o    = r_oe;
  assign RAM_RDAT_o  = r_ram[RAM_RADR_i];
  assign DISP_ON_o   = r_disp_on;
  assign BRIGHT_o    = r_bright;
  assign FRAME_ERR_o = r_frame_err;
  assign DBG_STATE_o = r_state;

endmodule
